uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// UART receiver framer (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a traffic/link indicator.
// Strobes are registered one clock after the stop-bit sample; there is no backpressure and each strobe lasts one clock.
module uart_rx_framer #(
  parameter int CLKRATE     = 1_789_773,
  parameter int BAUDRATE    = 9600,
  parameter int LINK_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       link
);

  localparam int BIT  = CLKRATE / BAUDRATE;
  localparam int HALF = BIT / 2;
  localparam int CW   = (BIT > 1) ? $clog2(BIT) : 1;
  localparam int LW   = $clog2(LINK_CYCLES + 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [LW-1:0] LINK_LOAD = LW'(LINK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rx_meta, r_rx_s;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bitn, w_bitn_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_data;
  logic            r_valid, w_valid_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic [LW-1:0]   r_link_cnt;
  logic            w_cnt_zero;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad, w_par_bad_nxt;
  logic            r_perr, w_perr_nxt;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = HALF_M1;
        end
      end
      S_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_rx_s) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = BIT_M1;
          w_bitn_nxt  = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          // LSB arrives first, so shift right and insert at the MSB
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = BIT_M1;
          w_bitn_nxt  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_par_bad_nxt = (r_rx_s != ^r_shift);
          w_cnt_nxt     = BIT_M1;
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_rx_s) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
        end else if (r_par_bad) begin
          w_perr_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_valid_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitn     <= 3'd0;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_link_cnt <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bitn     <= w_bitn_nxt;
      r_shift    <= w_shift_nxt;
      r_valid    <= w_valid_nxt;
      r_ferr     <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= w_par_bad_nxt;
      r_perr     <= w_perr_nxt;
`endif
      if (w_valid_nxt) r_data <= r_shift;
      // link rises together with valid and counts down from there
      if (w_valid_nxt)            r_link_cnt <= LINK_LOAD;
      else if (r_link_cnt != '0)  r_link_cnt <= r_link_cnt - LW'(1);
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign link      = (r_link_cnt != '0);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: vector table, corner sequences and randomized frames vs a frame-level model.
module tb_uart_rx_framer;

  localparam int BIT   = 16;
  localparam int LINKC = 64;
  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_FERR  = 2;
  localparam int EV_PERR  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, link;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         k;
    logic [7:0] d;
  } ev_t;
  ev_t obs_q[$];

  typedef struct {
    logic [7:0] b;
    int         stop_low;
    bit         pflip;
    int         exp_k;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl[7];

  int  since = 1000;
  time last_valid_t = 0;
  int  link_fail_prints = 0;
  logic [7:0] m_data = 8'h00;

  uart_rx_framer #(.CLKRATE(160), .BAUDRATE(10), .LINK_CYCLES(LINKC)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .link(link)
  );

  always #5 clk = ~clk;

  // Monitor: collect strobes, check exclusivity and the link hold window every cycle
  always @(negedge clk) begin
    if (!rst_n) since = 1000;
    else if (valid === 1'b1) begin
      since = 0;
      last_valid_t = $time;
    end else if (since < 1000) since = since + 1;
    checks = checks + 1;
    if (link !== (since < LINKC)) begin
      errors = errors + 1;
      if (link_fail_prints < 5)
        $display("FAIL link t=%0t got=%b expected=%b", $time, link, (since < LINKC));
      link_fail_prints = link_fail_prints + 1;
    end
    if (valid || frame_err || parity_err) begin
      checks = checks + 1;
      if ((int'(valid) + int'(frame_err) + int'(parity_err)) != 1) begin
        errors = errors + 1;
        $display("FAIL strobe_exclusive t=%0t got v=%b f=%b p=%b expected one", $time, valid, frame_err, parity_err);
      end
      obs_q.push_back('{valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR), data});
    end
  end

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pflip);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ pflip, BIT);
`endif
    if (stop_low > 0) drive(1'b0, stop_low);
    drive(1'b1, BIT);
    drive(1'b1, 4);
  endtask

  task automatic check_events(input int exp_k, input logic [7:0] exp_d, input string name);
    bit ok;
    checks = checks + 1;
    if (exp_k == EV_NONE) ok = (obs_q.size() == 0);
    else ok = (obs_q.size() == 1) && (obs_q[0].k == exp_k) && (obs_q[0].d === exp_d);
    if (!ok) begin
      errors = errors + 1;
      if (obs_q.size() > 0)
        $display("FAIL %s event: got n=%0d kind=%0d data=%h expected kind=%0d data=%h",
                 name, obs_q.size(), obs_q[0].k, obs_q[0].d, exp_k, exp_d);
      else
        $display("FAIL %s event: got none expected kind=%0d data=%h", name, exp_k, exp_d);
    end
    checks = checks + 1;
    if (data !== exp_d) begin
      errors = errors + 1;
      $display("FAIL %s data_out: got=%h expected=%h", name, data, exp_d);
    end
    obs_q.delete();
  endtask

  task automatic check_bit(input logic got, input logic exp, input string name);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  initial begin
    time vt, ft;
    int  n;
    tbl[0] = '{8'hA5, 0,  1'b0, EV_VALID, 8'hA5};
    tbl[1] = '{8'h3C, 40, 1'b0, EV_FERR,  8'hA5};
    tbl[2] = '{8'h01, 0,  1'b0, EV_VALID, 8'h01};
    tbl[3] = '{8'h00, 0,  1'b0, EV_VALID, 8'h00};
    tbl[4] = '{8'hFF, 0,  1'b0, EV_VALID, 8'hFF};
    tbl[5] = '{8'h80, 24, 1'b0, EV_FERR,  8'hFF};
    tbl[6] = '{8'h7E, 0,  1'b0, EV_VALID, 8'h7E};

    rst_n = 1'b0;
    rx    = 1'b1;
    drive(1'b1, 5);
    checks = checks + 1;
    if (data !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_data: got=%h expected=00", data);
    end
    check_bit(valid, 1'b0, "reset_valid");
    check_bit(frame_err, 1'b0, "reset_frame_err");
    check_bit(parity_err, 1'b0, "reset_parity_err");
    check_bit(link, 1'b0, "reset_link");
    rst_n = 1'b1;
    drive(1'b1, 10);

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].b, tbl[i].stop_low, tbl[i].pflip);
      drive(1'b1, BIT);
      check_events(tbl[i].exp_k, tbl[i].exp_d, $sformatf("vec%0d", i));
    end
    m_data = 8'h7E;

    // Short low pulse while idle must be rejected, and the receiver must stay usable
    drive(1'b0, 4);
    drive(1'b1, 3 * BIT);
    check_events(EV_NONE, 8'h7E, "glitch");
    send_frame(8'hC3, 0, 1'b0);
    check_events(EV_VALID, 8'hC3, "after_glitch");

    // Back-to-back bytes, then link must drop exactly LINKC clocks after the last valid
    send_frame(8'h11, 0, 1'b0);
    check_events(EV_VALID, 8'h11, "b2b_first");
    send_frame(8'h22, 0, 1'b0);
    check_events(EV_VALID, 8'h22, "b2b_second");
    vt = last_valid_t - 5;
    n = 0;
    while (link === 1'b1 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    ft = $time - 2;
    checks = checks + 1;
    if (link !== 1'b0 || (ft - vt) != LINKC * 10) begin
      errors = errors + 1;
      $display("FAIL link_fall: got link=%b after %0t expected 0 after %0t", link, ft - vt, LINKC * 10);
    end
    m_data = 8'h22;

    // Reset pulse in the middle of data bit 4 of 0xFF
    drive(1'b0, BIT);
    drive(1'b1, 4 * BIT + 5);
    rst_n = 1'b0;
    drive(1'b1, 2);
    check_bit(valid, 1'b0, "midrst_valid");
    check_bit(link, 1'b0, "midrst_link");
    checks = checks + 1;
    if (data !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL midrst_data: got=%h expected=00", data);
    end
    rst_n = 1'b1;
    drive(1'b1, 5 * BIT);
    m_data = 8'h00;
    check_events(EV_NONE, m_data, "midrst_abort");
    send_frame(8'h5A, 0, 1'b0);
    m_data = 8'h5A;
    check_events(EV_VALID, m_data, "after_reset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 0, 1'b1);
    check_events(EV_PERR, m_data, "parity_bad");
    send_frame(8'h07, 0, 1'b0);
    m_data = 8'h07;
    check_events(EV_VALID, m_data, "parity_good");
`endif

    // Randomized frames checked against the frame-level outcome rules
    for (int it = 0; it < 30; it++) begin
      int         r, kind, slow;
      bit         pf;
      logic [7:0] b;
      r    = int'($urandom_range(0, 9));
      b    = 8'($urandom);
      slow = 0;
      pf   = 1'b0;
      drive(1'b1, int'($urandom_range(0, 12)));
      if (r == 0) begin
        drive(1'b0, int'($urandom_range(1, 5)));
        drive(1'b1, 2 * BIT);
        kind = EV_NONE;
      end else begin
        if (r == 1) slow = int'($urandom_range(BIT, 40));
`ifdef UART_RX_PARITY_EN
        if (r == 2) pf = 1'b1;
`endif
        send_frame(b, slow, pf);
        if (slow > 0) kind = EV_FERR;
        else if (pf) kind = EV_PERR;
        else begin
          kind = EV_VALID;
          m_data = b;
        end
      end
      check_events(kind, m_data, $sformatf("rand%0d", it));
    end

    drive(1'b1, 2 * LINKC);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
